// File: rtl/ysyx_22040365_ctrl_if.sv
// rtl/ysyx_22040365_ctrl_if.sv - instruction memory fetch handshake bundle
interface ysyx_22040365_ctrl_if;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_rdy;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdy,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdy,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/ysyx_22040365_ctrl.sv
// rtl/ysyx_22040365_ctrl.sv - multi-cycle fetch/execute sequencer owning pc and instruction register
module ysyx_22040365_ctrl #(
    parameter logic [63:0] PC_RESET = 64'h8000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    ysyx_22040365_ctrl_if.master         imem,
    output logic [31:0]                  inst,
    input  logic                         dec_legal,
    output logic                         rf_wen,
    output logic [63:0]                  pc,
    output logic                         busy,
    output logic                         halt,
    output logic [1:0]                   halt_code,
    output logic [63:0]                  retire_cnt
);
    localparam logic [31:0] INST_NOP    = 32'h0000_0013;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [7:0]  TIMER_LAST  = TIMEOUT - 8'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t      state, state_next;
    logic [7:0]  timer, timer_next;
    logic [63:0] pc_next, retire_next;
    logic [31:0] inst_next;
    logic [1:0]  code_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            pc         <= PC_RESET;
            inst       <= INST_NOP;
            timer      <= 8'd0;
            retire_cnt <= 64'd0;
            halt_code  <= 2'd0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            inst       <= inst_next;
            timer      <= timer_next;
            retire_cnt <= retire_next;
            halt_code  <= code_next;
        end
    end

    always_comb begin
        state_next  = state;
        timer_next  = timer;
        pc_next     = pc;
        inst_next   = inst;
        retire_next = retire_cnt;
        code_next   = halt_code;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_FETCH;
                    timer_next = 8'd0;
                end
            end
            S_FETCH: begin
                if (imem.imem_rdy) begin
                    state_next = S_WAIT;
                    timer_next = timer + 8'd1;
                end else if (timer >= TIMER_LAST) begin
                    state_next = S_HALT;
                    code_next  = 2'd2;
                end else begin
                    timer_next = timer + 8'd1;
                end
            end
            S_WAIT: begin
                // The >= guards against a request accepted on the very last
                // budget cycle leaving the timer past the compare point.
                if (imem.imem_rvalid) begin
                    state_next = S_EXEC;
                    inst_next  = imem.imem_rdata;
                    timer_next = 8'd0;
                end else if (timer >= TIMER_LAST) begin
                    state_next = S_HALT;
                    code_next  = 2'd2;
                end else begin
                    timer_next = timer + 8'd1;
                end
            end
            S_EXEC: begin
                if (inst == INST_EBREAK) begin
                    state_next = S_HALT;
                    code_next  = 2'd0;
                end else if (!dec_legal) begin
                    state_next = S_HALT;
                    code_next  = 2'd1;
                end else begin
                    state_next = S_WB;
                end
            end
            S_WB: begin
                state_next  = S_FETCH;
                timer_next  = 8'd0;
                pc_next     = pc + 64'd4;
                retire_next = retire_cnt + 64'd1;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // All handshake and status outputs are pure functions of the registered state.
    assign imem.imem_req  = (state == S_FETCH);
    assign imem.imem_addr = pc;
    assign rf_wen         = (state == S_WB);
    assign busy           = (state != S_IDLE) && (state != S_HALT);
    assign halt           = (state == S_HALT);
endmodule

// File: doc/ysyx_22040365_ctrl.md
Name: ysyx_22040365_ctrl

Overview:
- Multi-cycle fetch/execute sequencer for the NPC core.
- Owns the PC and instruction register. Fetches each instruction over a req/rdy + rvalid handshake to instruction memory and presents the latched instruction to the decoder.
- Gives the decode/ex path one cycle to settle, then pulses the regfile write enable for exactly one cycle.
- Stops the core on ebreak, an illegal instruction, or a fetch timeout, and reports the cause to the simulation environment.

Parameters:
- PC_RESET, 64'h8000_0000, PC value loaded on reset.
- TIMEOUT, 8'd255, maximum cycles spent in FETCH+WAIT for one instruction before halting.

Ports:
- clk  in  1  core clock; all state changes on posedge.
- rst  in  1  synchronous reset, active-low; sampled on posedge clk.
- start  in  1  begin execution; sampled only in IDLE.
- imem_req  out  1  fetch request.
- imem_addr  out  64  fetch address, equal to pc.
- imem_rdy  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  fetch data valid.
- imem_rdata  in  32  fetched instruction.
- inst  out  32  instruction register, feeds the decoder.
- dec_legal  in  1  decoder recognises inst; valid in EXEC.
- rf_wen  out  1  regfile write enable.
- pc  out  64  current PC.
- busy  out  1  state is neither IDLE nor HALT.
- halt  out  1  core stopped (sticky).
- halt_code  out  2  0=ebreak, 1=illegal, 2=timeout.
- retire_cnt  out  64  instructions retired.

Behaviour:
- Reset (rst==0 at posedge) applies to every state:
  - Values: state=IDLE, pc=PC_RESET, inst=32'h0000_0013 (nop), timer=0, retire_cnt=0, halt=0, halt_code=0.
  - Outputs: imem_req=0, rf_wen=0, busy=0.
  - Reset overrides every other event in the same cycle, including reset asserted mid-fetch: imem_req drops the next cycle, and a late imem_rvalid is ignored.
- Moore FSM. imem_req, rf_wen, busy and halt are decoded from the registered state only, never from inputs. States:
  - IDLE: no outputs active. start=1 -> FETCH. Otherwise stay.
  - FETCH:
    - imem_req=1 and imem_addr=pc, both held stable until imem_rdy=1 at a posedge.
    - On imem_rdy=1: go to WAIT, and imem_req is 0 in the next cycle.
    - timer increments each cycle.
  - WAIT:
    - imem_req=0.
    - imem_rvalid=1: inst<=imem_rdata, timer<=0, go to EXEC.
    - Otherwise timer increments.
    - imem_rvalid is ignored in every state other than WAIT.
  - Timeout: in FETCH or WAIT, if timer==TIMEOUT-1 and the state's completion event is absent -> HALT with halt_code=2. This corresponds to TIMEOUT cycles without completion.
  - EXEC: one settle cycle; no write. Checks are applied in priority order:
    - inst==32'h0010_0073 -> HALT with halt_code=0.
    - else dec_legal==0 -> HALT with halt_code=1.
    - else -> WB.
  - WB:
    - rf_wen=1 for exactly this cycle.
    - At the posedge: pc<=pc+4 (64-bit, wraps modulo 2^64), retire_cnt<=retire_cnt+1 (wraps), then -> FETCH.
  - HALT: halt=1; imem_req=0, rf_wen=0; start ignored. Left only via reset.
- Ordering and counters:
  - An instruction halted in EXEC does not retire and does not advance the pc.
  - The pc shown during HALT is the address of the ebreak or offending instruction.
  - The timer resets to 0 on entry to FETCH.
- Throughput:
  - Minimum 4 cycles per instruction (FETCH with imem_rdy same cycle, WAIT with imem_rvalid next cycle, EXEC, WB).
  - Back-to-back instructions: WB goes to FETCH with no IDLE gap.
- x0 writes are the regfile's responsibility; the controller asserts rf_wen regardless of rd.
- The instruction register updates only in WAIT on imem_rvalid, so inst is stable throughout EXEC and WB.

Test Plan:
- Reset then start=1, memory with imem_rdy and imem_rvalid always 1, legal addi at 0x80000000 -> imem_req high in cycle 1, rf_wen high only in cycle 4, pc=0x80000004, retire_cnt=1, next imem_req in cycle 5.
- Program of 3 legal instructions then 32'h00100073 -> 3 single-cycle rf_wen pulses; then halt=1, halt_code=0, pc=0x8000000C, retire_cnt=3, imem_req stays 0.
- imem_rdy held low 3 cycles, then imem_rvalid 2 cycles later -> imem_req and imem_addr stable for 4 cycles, one fetch completes, no timeout.
- dec_legal=0 in EXEC -> no rf_wen, halt_code=1, retire_cnt unchanged. Also imem_rvalid never arrives -> halt_code=2 after exactly 255 cycles in FETCH+WAIT.
- rst=0 asserted while in WAIT, then imem_rvalid=1 the following cycle -> state IDLE, inst=0x00000013, pc=0x80000000, imem_req=0, rvalid ignored. Also start=1 while in HALT has no effect.
